// File: rtl/alu_pkg.sv
// Shared definitions for the serial-protocol ALU and its command driver.
//   alu_op_e       : command opcode encoding carried on cmd_op / serial opcode beats
//   drv_state_e    : command driver FSM state encoding
//   ALU_DATA_WIDTH : default operand/result width shared with the ALU
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_PAR  = 2'b10,
        OP_COMP = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        DRV_IDLE   = 3'd0,
        DRV_SEND_A = 3'd1,
        DRV_SEND_B = 3'd2,
        DRV_WAIT   = 3'd3,
        DRV_RESP   = 3'd4
    } drv_state_e;

endpackage

// File: rtl/alu_watchdog.sv
// Watchdog counter for the ALU wait phase.
//   clk, reset_n : clock, synchronous active-low reset
//   clr_i        : force the count to zero (held while not waiting)
//   en_i         : count one cycle of waiting
//   expire_c     : combinational; high on the TIMEOUT_CYCLES-th enabled cycle
module alu_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count k during the k-th wait cycle, so the terminal value is TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (!reset_n || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/alu_cmd_driver.sv
// Command driver for the serial-protocol ALU: takes a parallel command over
// valid/ready, issues the two-beat opcode/data sequence, waits for alu_done
// (guarded by a watchdog) and returns the result over a valid/ready channel.
// Optional statistics counters are enabled with ALU_CMD_DRIVER_STATS_EN.
//   clk, reset_n                 : clock, synchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake (cmd_ready decoded from state)
//   cmd_op, cmd_a, cmd_b         : command payload, sampled at the handshake
//   alu_opcode_valid/opcode/data : serial beats to the ALU
//   alu_done/result/overflow     : ALU completion
//   rsp_valid/rsp_ready          : response handshake
//   rsp_result/overflow/timeout  : response payload
//   fault                        : sticky ALU-hung flag
//   stat_cmds/stat_ovf/stat_tmo  : saturating counters (ALU_CMD_DRIVER_STATS_EN only)
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ALU_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  alu_opcode_valid,
    output logic                  alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
`ifdef ALU_CMD_DRIVER_STATS_EN
    output logic [15:0]           stat_cmds,
    output logic [15:0]           stat_ovf,
    output logic [7:0]            stat_tmo,
`endif
    output logic                  fault
);

    localparam logic [2:0] ST_IDLE   = DRV_IDLE;
    localparam logic [2:0] ST_SEND_A = DRV_SEND_A;
    localparam logic [2:0] ST_SEND_B = DRV_SEND_B;
    localparam logic [2:0] ST_WAIT   = DRV_WAIT;
    localparam logic [2:0] ST_RESP   = DRV_RESP;

    logic [2:0]            state_q, state_d;
    logic                  op_hi_q, op_hi_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  beat_valid_q, beat_valid_d;
    logic                  beat_op_q, beat_op_d;
    logic [DATA_WIDTH-1:0] beat_data_q, beat_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_ovf_q, rsp_ovf_d;
    logic                  rsp_tmo_q, rsp_tmo_d;
    logic                  fault_q, fault_d;
    logic                  wd_clr, wd_en, wd_expire;
    logic                  rsp_hs, tmo_fire;

    alu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .expire_c(wd_expire)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !fault_q;
    assign rsp_hs    = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
    // alu_done takes priority over a watchdog expiry in the same cycle.
    assign tmo_fire  = (state_q == ST_WAIT) && !alu_done && wd_expire;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            op_hi_q      <= 1'b0;
            b_q          <= '0;
            beat_valid_q <= 1'b0;
            beat_op_q    <= 1'b0;
            beat_data_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_tmo_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_hi_q      <= op_hi_d;
            b_q          <= b_d;
            beat_valid_q <= beat_valid_d;
            beat_op_q    <= beat_op_d;
            beat_data_q  <= beat_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_tmo_q    <= rsp_tmo_d;
            fault_q      <= fault_d;
        end
    end

    // Next state; beat outputs are computed for the state being entered so
    // they line up with it.
    always_comb begin
        state_d      = state_q;
        op_hi_d      = op_hi_q;
        b_d          = b_q;
        beat_valid_d = 1'b0;
        beat_op_d    = 1'b0;
        beat_data_d  = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_tmo_d    = rsp_tmo_q;
        fault_d      = fault_q;
        wd_clr       = 1'b1;
        wd_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_hi_d      = cmd_op[1];
                    b_d          = cmd_b;
                    beat_valid_d = 1'b1;
                    beat_op_d    = cmd_op[0];
                    beat_data_d  = cmd_a;
                    state_d      = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                beat_valid_d = 1'b1;
                beat_op_d    = op_hi_q;
                beat_data_d  = b_q;
                state_d      = ST_SEND_B;
            end
            ST_SEND_B: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_clr = 1'b0;
                wd_en  = 1'b1;
                if (alu_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_ovf_d    = alu_overflow;
                    rsp_tmo_d    = 1'b0;
                    state_d      = ST_RESP;
                end else if (tmo_fire) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_ovf_d    = 1'b0;
                    rsp_tmo_d    = 1'b1;
                    fault_d      = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign alu_opcode_valid = beat_valid_q;
    assign alu_opcode       = beat_op_q;
    assign alu_data         = beat_data_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_result       = rsp_result_q;
    assign rsp_overflow     = rsp_ovf_q;
    assign rsp_timeout      = rsp_tmo_q;
    assign fault            = fault_q;

`ifdef ALU_CMD_DRIVER_STATS_EN
    logic [15:0] stat_cmds_q;
    logic [15:0] stat_ovf_q;
    logic [7:0]  stat_tmo_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_cmds_q <= '0;
            stat_ovf_q  <= '0;
            stat_tmo_q  <= '0;
        end else begin
            if (rsp_hs && (stat_cmds_q != '1)) begin
                stat_cmds_q <= stat_cmds_q + 16'd1;
            end
            if (rsp_hs && rsp_ovf_q && (stat_ovf_q != '1)) begin
                stat_ovf_q <= stat_ovf_q + 16'd1;
            end
            if (tmo_fire && (stat_tmo_q != '1)) begin
                stat_tmo_q <= stat_tmo_q + 8'd1;
            end
        end
    end

    assign stat_cmds = stat_cmds_q;
    assign stat_ovf  = stat_ovf_q;
    assign stat_tmo  = stat_tmo_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench for alu_cmd_driver; the bench plays the ALU
// and drives alu_done with hand-computed results at chosen wait cycles.
module tb_alu_cmd_driver;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic          alu_opcode_valid;
    logic          alu_opcode;
    logic [DW-1:0] alu_data;
    logic          alu_done;
    logic [DW-1:0] alu_result;
    logic          alu_overflow;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;
    logic          fault;
`ifdef ALU_CMD_DRIVER_STATS_EN
    logic [15:0]   stat_cmds;
    logic [15:0]   stat_ovf;
    logic [7:0]    stat_tmo;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .alu_opcode_valid(alu_opcode_valid),
        .alu_opcode      (alu_opcode),
        .alu_data        (alu_data),
        .alu_done        (alu_done),
        .alu_result      (alu_result),
        .alu_overflow    (alu_overflow),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_overflow    (rsp_overflow),
        .rsp_timeout     (rsp_timeout),
`ifdef ALU_CMD_DRIVER_STATS_EN
        .stat_cmds       (stat_cmds),
        .stat_ovf        (stat_ovf),
        .stat_tmo        (stat_tmo),
`endif
        .fault           (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; alu_done is returned in wait cycle kdone (kdone < 0: never).
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int kdone, input logic [DW-1:0] res, input logic ovf);
        int kend;
        kend = (kdone >= 0) ? kdone : int'(TMO) - 1;
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        step();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_a     = ~a;
        cmd_b     = ~b;
        chk("beat_a_valid", 32'(alu_opcode_valid), 1);
        chk("beat_a_op", 32'(alu_opcode), 32'(op[0]));
        chk("beat_a_data", 32'(alu_data), 32'(a));
        chk("busy_cmd_ready", 32'(cmd_ready), 0);
        step();
        chk("beat_b_valid", 32'(alu_opcode_valid), 1);
        chk("beat_b_op", 32'(alu_opcode), 32'(op[1]));
        chk("beat_b_data", 32'(alu_data), 32'(b));
        step();
        chk("wait_beat_valid", 32'(alu_opcode_valid), 0);
        chk("wait_data", 32'(alu_data), 0);
        for (int k = 0; k <= kend; k++) begin
            chk("wait_no_rsp", 32'(rsp_valid), 0);
            if (k == kdone) begin
                alu_done     = 1'b1;
                alu_result   = res;
                alu_overflow = ovf;
            end
            step();
            alu_done     = 1'b0;
            alu_result   = 8'hAA;
            alu_overflow = 1'b1;
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        if (kdone >= 0) begin
            chk("rsp_result", 32'(rsp_result), 32'(res));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(ovf));
            chk("rsp_timeout", 32'(rsp_timeout), 0);
            chk("fault_clear", 32'(fault), 0);
        end else begin
            chk("tmo_result", 32'(rsp_result), 0);
            chk("tmo_overflow", 32'(rsp_overflow), 0);
            chk("tmo_flag", 32'(rsp_timeout), 1);
            chk("tmo_fault", 32'(fault), 1);
        end
    endtask

    task automatic accept_rsp(input logic exp_ready);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 0);
        chk("post_rsp_cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_a        = '0;
        cmd_b        = '0;
        alu_done     = 1'b0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        rsp_ready    = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_beat_valid", 32'(alu_opcode_valid), 0);
        chk("rst_opcode", 32'(alu_opcode), 0);
        chk("rst_data", 32'(alu_data), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_ovf", 32'(rsp_overflow), 0);
        chk("rst_rsp_tmo", 32'(rsp_timeout), 0);
        chk("rst_fault", 32'(fault), 0);

        // alu_done while idle is ignored
        alu_done   = 1'b1;
        alu_result = 8'hFF;
        step();
        alu_done = 1'b0;
        chk("idle_done_ignored", 32'(rsp_valid), 0);
        chk("idle_done_ready", 32'(cmd_ready), 1);

        // 1: ADD 12+34, done 4 cycles after wait entry
        run_cmd(2'b00, 8'h12, 8'h34, 3, 8'h46, 1'b0);
        accept_rsp(1'b1);

        // 2: ADD F0+20 overflows, then SUB 05-03
        run_cmd(2'b00, 8'hF0, 8'h20, 1, 8'h10, 1'b1);
        accept_rsp(1'b1);
        run_cmd(2'b01, 8'h05, 8'h03, 2, 8'h02, 1'b0);
        accept_rsp(1'b1);

        // 3: COMP ~3C with backpressure; stray alu_done must not disturb payload
        run_cmd(2'b11, 8'h3C, 8'h00, 0, 8'hC3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_result", 32'(rsp_result), 32'h0000_00C3);
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
            if (i == 2) begin
                alu_done   = 1'b1;
                alu_result = 8'h11;
            end
            step();
            alu_done = 1'b0;
        end
        accept_rsp(1'b1);

        // done on the watchdog's last cycle wins over the timeout
        run_cmd(2'b01, 8'h09, 8'h04, int'(TMO) - 1, 8'h05, 1'b0);
        accept_rsp(1'b1);

        // 4: no done -> timeout after exactly TMO wait cycles, sticky fault
        run_cmd(2'b00, 8'h77, 8'h11, -1, 8'h00, 1'b0);
        accept_rsp(1'b0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fault_cmd_ready", 32'(cmd_ready), 0);
            chk("fault_no_beat", 32'(alu_opcode_valid), 0);
            chk("fault_sticky", 32'(fault), 1);
        end
        cmd_valid = 1'b0;
`ifdef ALU_CMD_DRIVER_STATS_EN
        // 6: five normal responses (one overflow) plus one timeout response
        chk("stat_cmds", 32'(stat_cmds), 6);
        chk("stat_ovf", 32'(stat_ovf), 1);
        chk("stat_tmo", 32'(stat_tmo), 1);
`endif
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset_fault_clr", 32'(fault), 0);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);
        chk("reset_tmo_clr", 32'(rsp_timeout), 0);

        // 5: reset mid-WAIT discards the command
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_a     = 8'h01;
        cmd_b     = 8'h02;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_beat_valid", 32'(alu_opcode_valid), 0);
        chk("midrst_data", 32'(alu_data), 0);
        alu_done   = 1'b1;
        alu_result = 8'h55;
        step();
        alu_done = 1'b0;
        chk("midrst_no_rsp", 32'(rsp_valid), 0);
        chk("midrst_result", 32'(rsp_result), 0);
        step();
        chk("midrst_no_rsp2", 32'(rsp_valid), 0);
`ifdef ALU_CMD_DRIVER_STATS_EN
        chk("stat_cmds_rst", 32'(stat_cmds), 0);
        chk("stat_tmo_rst", 32'(stat_tmo), 0);
`endif
        // PAR of B4 (four ones) -> 0
        run_cmd(2'b10, 8'hB4, 8'h00, 2, 8'h00, 1'b0);
        accept_rsp(1'b1);
`ifdef ALU_CMD_DRIVER_STATS_EN
        chk("stat_cmds_after", 32'(stat_cmds), 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
